// File: rtl/phase_decoder.sv
// phase_decoder: locks onto the 5-phase one-hot ring (IF->ID->EX->MEM->WB),
// issues registered per-stage enables, flags ring violations with a sticky
// error and counts retired instructions (one per accepted WB phase).
module phase_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       in_phase,
    input  logic             phase_hold,
    input  logic             err_clr,
    output logic             en_if,
    output logic             en_id,
    output logic             en_ex,
    output logic             en_mem,
    output logic             en_wb,
    output logic             locked,
    output logic             phase_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_ONEHOT  = 2'b01;
    localparam logic [1:0] CODE_ORDER   = 2'b10;
    localparam logic [1:0] CODE_REPEAT  = 2'b11;

    state_t             state_q, state_d;
    logic [4:0]         last_q, last_d;
    logic [4:0]         en_q, en_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [CNT_W-1:0]   retire_q, retire_d;

    logic               accept;
    logic [1:0]         cause;
    logic               is_onehot;
    logic [4:0]         next_phase;

    // Ring helpers: one-hot test and the phase expected after the last accepted one.
    assign is_onehot  = (in_phase != 5'b00000) && ((in_phase & (in_phase - 5'b00001)) == 5'b00000);
    assign next_phase = {last_q[3:0], last_q[4]};

    // State register plus all registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_UNSYNC;
            last_q     <= 5'b00000;
            en_q       <= 5'b00000;
            err_code_q <= CODE_NONE;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            en_q       <= en_d;
            err_code_q <= err_code_d;
            retire_q   <= retire_d;
        end
    end

    // Next-state logic: classify the sampled phase in priority order.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        cause   = CODE_NONE;
        unique case (state_q)
            ST_UNSYNC: begin
                if (in_phase == 5'b00001) begin
                    state_d = ST_SYNC;
                    accept  = 1'b1;
                end
            end
            ST_SYNC: begin
                if (!is_onehot) begin
                    state_d = ST_ERROR;
                    cause   = CODE_ONEHOT;
                end else if (in_phase == next_phase) begin
                    accept  = 1'b1;
                end else if (in_phase == last_q) begin
                    // A repeat is only legal while upstream is stalling.
                    if (!phase_hold) begin
                        state_d = ST_ERROR;
                        cause   = CODE_REPEAT;
                    end
                end else begin
                    state_d = ST_ERROR;
                    cause   = CODE_ORDER;
                end
            end
            ST_ERROR: begin
                if (err_clr) begin
                    state_d = ST_UNSYNC;
                end
            end
            default: begin
                state_d = ST_UNSYNC;
            end
        endcase
    end

    // Output logic: next values of enables, last phase, error code and retire count.
    always_comb begin
        en_d       = accept ? in_phase : 5'b00000;
        last_d     = accept ? in_phase : last_q;
        retire_d   = (accept && in_phase[4]) ? retire_q + 1'b1 : retire_q;
        err_code_d = err_code_q;
        if (state_q == ST_ERROR) begin
            // Frozen at the first cause until cleared.
            if (err_clr) begin
                err_code_d = CODE_NONE;
            end
        end else if (state_d == ST_ERROR) begin
            err_code_d = cause;
        end
    end

    assign en_if      = en_q[0];
    assign en_id      = en_q[1];
    assign en_ex      = en_q[2];
    assign en_mem     = en_q[3];
    assign en_wb      = en_q[4];
    assign locked     = (state_q == ST_SYNC);
    assign phase_err  = (state_q == ST_ERROR);
    assign err_code   = err_code_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_phase_decoder.sv
// Bench for phase_decoder: directed phase sequences, an index-based ring model
// checked every cycle, and literal expectations at key points.
module tb_phase_decoder;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       in_phase = 5'b00000;
    logic             phase_hold = 1'b0;
    logic             err_clr = 1'b0;
    logic             en_if, en_id, en_ex, en_mem, en_wb;
    logic             locked, phase_err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] retire_cnt;

    int total = 0;
    int bad   = 0;

    // Model state: ring position as an index 0..4 (-1 = none).
    logic [4:0] m_en = 5'b0;
    bit         m_locked = 1'b0;
    bit         m_err = 1'b0;
    logic [1:0] m_code = 2'b00;
    int         m_cnt = 0;
    int         m_last = -1;
    bit         armed = 1'b0;

    phase_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_phase(in_phase), .phase_hold(phase_hold),
        .err_clr(err_clr), .en_if(en_if), .en_id(en_id), .en_ex(en_ex),
        .en_mem(en_mem), .en_wb(en_wb), .locked(locked), .phase_err(phase_err),
        .err_code(err_code), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int phase_idx(input logic [4:0] ph);
        int idx = -1;
        for (int k = 0; k < 5; k++) if (ph == (5'b00001 << k)) idx = k;
        return idx;
    endfunction

    task automatic model_err(input logic [1:0] c);
        m_err = 1'b1; m_locked = 1'b0; m_code = c;
    endtask

    // Apply the ring rules to the inputs sampled at this edge.
    task automatic model_update();
        int idx;
        m_en = 5'b0;
        if (rst) begin
            m_locked = 0; m_err = 0; m_code = 2'b00; m_cnt = 0; m_last = -1;
        end else if (m_err) begin
            if (err_clr) begin m_err = 0; m_code = 2'b00; end
        end else if (!m_locked) begin
            if (in_phase == 5'b00001) begin m_locked = 1; m_last = 0; m_en = in_phase; end
        end else begin
            idx = phase_idx(in_phase);
            if ($countones(in_phase) != 1) model_err(2'b01);
            else if (idx == (m_last + 1) % 5) begin
                m_last = idx; m_en = in_phase;
                if (idx == 4) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end else if (idx == m_last) begin
                if (!phase_hold) model_err(2'b11);
            end else model_err(2'b10);
        end
    endtask

    task automatic step(input logic [4:0] ph, input logic hold, input logic clr, input logic r);
        @(negedge clk);
        in_phase = ph; phase_hold = hold; err_clr = clr; rst = r;
        @(posedge clk);
        model_update();
        armed = 1'b1;
    endtask

    task automatic ring();
        step(5'b00010, 0, 0, 0); step(5'b00100, 0, 0, 0);
        step(5'b01000, 0, 0, 0); step(5'b10000, 0, 0, 0);
        step(5'b00001, 0, 0, 0);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("en", {en_wb, en_mem, en_ex, en_id, en_if}, m_en);
            chk("locked", locked, m_locked);
            chk("phase_err", phase_err, m_err);
            chk("err_code", err_code, m_code);
            chk("retire_cnt", retire_cnt, m_cnt);
        end
    end

    initial begin
        // Reset and lock-on, full ring.
        step(5'b00000, 0, 0, 1); step(5'b00000, 0, 0, 1);
        #2; chk("lit_rst_cnt", retire_cnt, 0); chk("lit_rst_locked", locked, 0);
        for (int i = 0; i < 3; i++) step(5'b00000, 0, 0, 0);
        #2; chk("lit_unsync_en", {en_wb, en_mem, en_ex, en_id, en_if}, 5'b00000);
        step(5'b00001, 0, 0, 0);
        #2; chk("lit_lock_if", {en_if, locked}, 2'b11);
        step(5'b00010, 0, 0, 0); step(5'b00100, 0, 0, 0); step(5'b01000, 0, 0, 0);
        step(5'b10000, 0, 0, 0);
        #2; chk("lit_wb", en_wb, 1); chk("lit_cnt1", retire_cnt, 1);
        step(5'b00001, 0, 0, 0);
        // Legal stall on EX then advance to MEM.
        step(5'b00010, 0, 0, 0); step(5'b00100, 0, 0, 0);
        step(5'b00100, 1, 0, 0); step(5'b00100, 1, 0, 0);
        #2; chk("lit_hold_en", {en_wb, en_mem, en_ex, en_id, en_if}, 5'b00000);
        step(5'b01000, 1, 0, 0);
        #2; chk("lit_mem", {en_mem, phase_err}, 2'b10);
        // Repeat without hold on ID.
        step(5'b10000, 0, 0, 0); step(5'b00001, 0, 0, 0); step(5'b00010, 0, 0, 0);
        step(5'b00010, 0, 0, 0);
        #2; chk("lit_repeat", {phase_err, err_code, locked}, 4'b1110);
        step(5'b00100, 0, 1, 0);
        #2; chk("lit_clr", {phase_err, err_code}, 3'b000);
        // Out of order, code frozen, then clear.
        step(5'b00001, 0, 0, 0); step(5'b01000, 0, 0, 0);
        #2; chk("lit_order", err_code, 2'b10);
        step(5'b00011, 0, 0, 0);
        #2; chk("lit_frozen", err_code, 2'b10);
        step(5'b00000, 0, 1, 0);
        #2; chk("lit_clr_cnt", retire_cnt, 2); chk("lit_clr_unsync", locked, 0);
        // Not one-hot while locked; err_clr in SYNC ignored.
        step(5'b00001, 0, 0, 0); step(5'b00001, 1, 1, 0);
        #2; chk("lit_clr_sync", {locked, phase_err}, 2'b10);
        step(5'b00000, 0, 0, 0);
        #2; chk("lit_onehot", err_code, 2'b01);
        step(5'b00000, 0, 1, 0);
        // Wrap: 17 rings with a 4-bit counter.
        step(5'b00000, 0, 0, 1);
        step(5'b00001, 0, 0, 0);
        for (int i = 0; i < 17; i++) ring();
        #2; chk("lit_wrap", retire_cnt, 1);
        // Reset mid-ring at MEM, WB afterwards must not be accepted.
        step(5'b00010, 0, 0, 0); step(5'b00100, 0, 0, 0); step(5'b01000, 0, 0, 0);
        step(5'b01000, 0, 0, 1);
        step(5'b10000, 0, 0, 0);
        #2; chk("lit_rst_wb", {en_wb, locked}, 2'b00); chk("lit_rst_cnt0", retire_cnt, 0);
        step(5'b00010, 0, 0, 0);
        step(5'b00001, 0, 0, 0);
        #2; chk("lit_relock", {locked, en_if}, 2'b11);
        step(5'b00010, 0, 0, 0);
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
